sequence_generator: RTL and testbench
=====================================

# sequence_generator

Serial pattern transmitter: the source end of the sequence-detector link. It loads a pattern word, its length and a repeat count on a `start` request, then shifts the pattern out one bit per clock with framing strobes. It sits upstream of `Sequence_Detector` and drives its serial input for bring-up and self-test.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default 4: width of `patLen`; must hold the value `PAT_W`.
- `CNT_W`, default 4: width of `repeatCnt`.
- `GAP`, default 2: idle cycles inserted between repetitions; 0 means back-to-back.

Ports:
- `clockPulse`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit; sampled only while `busy` = 0.
- `pattern`  in  `PAT_W`  bits to send, LSB-aligned; sampled with `start`.
- `patLen`  in  `LEN_W`  number of bits to send; sampled with `start`.
- `repeatCnt`  in  `CNT_W`  number of repetitions; sampled with `start`.
- `serialOut`  out  1  serial data bit.
- `bitValid`  out  1  high while `serialOut` carries a pattern bit.
- `frameStart`  out  1  high on the first bit of each repetition.
- `busy`  out  1  high from acceptance of `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the final bit of the final repetition.

## Operation
- All outputs are registered.
- States and transitions:
  - IDLE → SHIFT on an accepted `start`.
  - SHIFT → GAP after the last bit, if repetitions remain and `GAP` > 0.
  - SHIFT → SHIFT (restart) after the last bit, if repetitions remain and `GAP` = 0.
  - SHIFT → DONE after the last bit of the final repetition.
  - GAP → SHIFT after `GAP` cycles.
  - DONE → IDLE after one cycle.
- Acceptance: `start` = 1 while in IDLE with `patLen` ≠ 0.
  - On acceptance, latch `pattern`, len = min(`patLen`, `PAT_W`) and reps = max(`repeatCnt`, 1).
  - `patLen` = 0 is ignored: the block stays in IDLE.
- Bit order: `pattern[len-1]` first, down to `pattern[0]`.
  - Bits above `len-1` are never sent.
  - A bit counter counts len-1 down to 0; a repetition counter counts reps down to 1.
- SHIFT:
  - `bitValid` = 1 and `serialOut` = the current bit.
  - `frameStart` = 1 only when the bit counter = len-1.
- GAP: `serialOut` = 0, `bitValid` = 0, `frameStart` = 0.
- DONE: `done` = 1 and `busy` = 1, with `bitValid` = 0 and `serialOut` = 0.
- IDLE: all outputs 0.
- `start` while `busy` = 1 is ignored; latched values do not change mid-transfer.
- Reset values: state IDLE, counters 0, and `serialOut`, `bitValid`, `frameStart`, `busy`, `done` all 0.

## Timing
- `start` accepted at rising edge N:
  - `busy` = 1 from edge N.
  - First bit and `frameStart` valid from edge N+1.
- One repetition occupies len consecutive cycles with `bitValid` = 1.
- Total streaming length is reps·len + (reps−1)·`GAP` cycles.
- `done` is high for exactly the cycle after the last bit; no trailing gap follows the final repetition.
- `busy` falls at the same edge `done` falls. The earliest new `start` is accepted at the following edge, so no bit is emitted in the done cycle.
- Reset asserted mid-operation:
  - All outputs go to 0 immediately, without waiting for a clock.
  - The transfer is aborted and no `done` pulse is produced.
  - After release, the block is in IDLE and accepts `start` on the first rising edge.
- `start` held high continuously: a new transfer begins at the first edge after `busy` drops.

## Test plan
- Reset hold: clock period 100 ns, `reset` = 0 for 200 ns, then `reset` = 1 and `start` = 0 → all outputs 0 throughout, no activity.
- `pattern` = 8'b1011_0110, `patLen` = 8, `repeatCnt` = 1 → `serialOut` = 1,0,1,1,0,1,1,0 over 8 cycles with `bitValid` = 1; `frameStart` on the first bit only; `done` 1 cycle later; `busy` high for 9 cycles after acceptance.
- `pattern` = 8'hA5, `patLen` = 3, `repeatCnt` = 3, `GAP` = 2 → sequence 101, 00 (gap), 101, 00 (gap), 101 with `bitValid` low during gaps; 3 `frameStart` pulses; `done` at cycle 14 after acceptance.
- Illegal and overlapping requests:
  - `patLen` = 0 → ignored, `busy` stays 0.
  - `patLen` = 12 → clamped, 8 bits sent.
  - Second `start` with a different pattern during `busy` → ignored, stream unchanged.
- Reset pulled low during the 4th bit of an 8-bit transfer → outputs 0 asynchronously, no `done`; after release, a new `start` with `pattern` = 8'h0F, `patLen` = 4 yields 1,1,1,1.
- `repeatCnt` = 0 → exactly one pass. `GAP` = 0 with `repeatCnt` = 2 and `patLen` = 2, `pattern` = 2'b10 → 1,0,1,0 contiguous, `bitValid` high for 4 cycles.

Source files
------------

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//
// Serial pattern transmitter that drives a sequence detector for bring-up and
// self-test. A start request loads a pattern word, its length and a repeat
// count. The pattern is then shifted out MSB-of-length first, one bit per
// clock, with framing strobes. Repetitions are separated by GAP idle cycles.
//
// Ports:
//   clockPulse  in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   transfer request, sampled only while idle
//   pattern     in   [PAT_W-1:0] bits to send, LSB-aligned
//   patLen      in   [LEN_W-1:0] number of bits to send (clamped to PAT_W)
//   repeatCnt   in   [CNT_W-1:0] number of repetitions (0 treated as 1)
//   serialOut   out  serial data bit
//   bitValid    out  high while serialOut carries a pattern bit
//   frameStart  out  high on the first bit of each repetition
//   busy        out  high from start acceptance through the done cycle
//   done        out  one-cycle pulse after the final bit
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start with nonzero patLen, all outputs low
// LOAD    | request accepted, busy high, first bit follows next cycle
// SHIFT   | one pattern bit per cycle, bit counter len-1 down to 0
// GAP     | idle spacing between repetitions
// DONE    | done pulse, busy still high, start not yet accepted
// -----------------------------------------------------------------------------
module sequence_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clockPulse,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] patLen,
  input  logic [CNT_W-1:0] repeatCnt,
  output logic             serialOut,
  output logic             bitValid,
  output logic             frameStart,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Gap counter holds GAP-1 down to 0; at least one bit wide even when unused.
  localparam int GAP_W    = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  logic [2:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [LEN_W-1:0] len_clamped;
  logic [CNT_W-1:0] reps_eff;
  logic [PAT_W-1:0] pat_shift;

  assign len_clamped = (patLen > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : patLen;
  assign reps_eff    = (repeatCnt == '0) ? CNT_W'(1) : repeatCnt;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && (patLen != '0)) begin
          state_d   = S_LOAD;
          pat_d     = pattern;
          len_d     = len_clamped;
          rep_cnt_d = reps_eff;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = len_q - LEN_W'(1);
      end
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end else if (rep_cnt_q > CNT_W'(1)) begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_W'(GAP_LOAD);
          end else begin
            // back-to-back: restart the frame without leaving SHIFT
            bit_cnt_d = len_q - LEN_W'(1);
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = S_SHIFT;
          bit_cnt_d = len_q - LEN_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register: the cycle labelled SHIFT is the cycle the bit is on the wire.
  assign pat_shift = pat_q >> bit_cnt_d;

  always_ff @(posedge clockPulse or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_ff @(posedge clockPulse or negedge reset) begin
    if (!reset) begin
      serialOut  <= 1'b0;
      bitValid   <= 1'b0;
      frameStart <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      serialOut  <= (state_d == S_SHIFT) && pat_shift[0];
      bitValid   <= (state_d == S_SHIFT);
      frameStart <= (state_d == S_SHIFT) && (bit_cnt_d == (len_q - LEN_W'(1)));
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
`timescale 1ns/1ps
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] patLen;
  logic [3:0] repeatCnt;

  logic so2, bv2, fs2, busy2, done2;
  logic so0, bv0, fs0, busy0, done0;

  sequence_generator #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(2)) u_dut2 (
    .clockPulse(clk), .reset(reset), .start(start), .pattern(pattern),
    .patLen(patLen), .repeatCnt(repeatCnt), .serialOut(so2), .bitValid(bv2),
    .frameStart(fs2), .busy(busy2), .done(done2)
  );

  sequence_generator #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clockPulse(clk), .reset(reset), .start(start), .pattern(pattern),
    .patLen(patLen), .repeatCnt(repeatCnt), .serialOut(so0), .bitValid(bv0),
    .frameStart(fs0), .busy(busy0), .done(done0)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected per-cycle outputs {busy, bitValid, serialOut, frameStart, done}
  logic [4:0] q2[$];
  logic [4:0] q0[$];
  int nxt2 = 0;
  int nxt0 = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (busy,bitValid,serialOut,frameStart,done)",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [4:0] e);
    if (inst == 2) q2.push_back(e);
    else q0.push_back(e);
  endtask

  // Reference: build the whole output trace of one transfer from its rules.
  task automatic model_accept(input int inst, input int k, input logic [7:0] p,
                              input int plen, input int rc);
    int len, reps, gap, n;
    logic [4:0] e;
    gap  = (inst == 2) ? 2 : 0;
    len  = (plen > 8) ? 8 : plen;
    reps = (rc == 0) ? 1 : rc;
    n = 0;
    push(inst, 5'b10000); n++;
    for (int r = 0; r < reps; r++) begin
      for (int i = len - 1; i >= 0; i--) begin
        e = {1'b1, 1'b1, p[i], (i == len - 1), 1'b0};
        push(inst, e); n++;
      end
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) begin push(inst, 5'b10000); n++; end
    end
    push(inst, 5'b10001); n++;
    if (inst == 2) nxt2 = k + n + 1;
    else nxt0 = k + n + 1;
  endtask

  task automatic model_edge(input int k, input logic s, input logic [7:0] p,
                            input logic [3:0] l, input logic [3:0] rc);
    if (s && l != 0) begin
      if (k >= nxt2) model_accept(2, k, p, int'(l), int'(rc));
      if (k >= nxt0) model_accept(0, k, p, int'(l), int'(rc));
    end
  endtask

  task automatic cyc_drive(input logic s, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] rc);
    @(negedge clk);
    #1;
    start = s; pattern = p; patLen = l; repeatCnt = rc;
    model_edge(cyc + 1, s, p, l, rc);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((cyc + 1 < nxt2 || cyc + 1 < nxt0) && guard < 1000) begin
      cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL wait_idle timeout cyc=%0d", cyc);
    end
    cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);
  endtask

  // Monitor: every cycle compares against the queued trace, or idle zeros.
  logic [4:0] e2, e0;
  always @(negedge clk) begin
    e2 = 5'b0;
    e0 = 5'b0;
    if (q2.size() > 0) e2 = q2.pop_front();
    if (q0.size() > 0) e0 = q0.pop_front();
    chk("stream_gap2", {busy2, bv2, so2, fs2, done2}, e2);
    chk("stream_gap0", {busy0, bv0, so0, fs0, done0}, e0);
  end

  initial begin
    reset = 1'b0; start = 1'b0; pattern = '0; patLen = '0; repeatCnt = '0;
    #210;
    reset = 1'b1;
    repeat (3) cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);

    // full 8-bit pattern, single pass
    cyc_drive(1'b1, 8'b1011_0110, 4'd8, 4'd1);
    wait_idle();

    // 3-bit pattern, three passes with gaps
    cyc_drive(1'b1, 8'hA5, 4'd3, 4'd3);
    wait_idle();

    // zero length ignored
    cyc_drive(1'b1, 8'hFF, 4'd0, 4'd2);
    repeat (3) cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);

    // over-length request clamps to 8
    cyc_drive(1'b1, 8'h6C, 4'd12, 4'd1);
    wait_idle();

    // second start during busy ignored
    cyc_drive(1'b1, 8'hC3, 4'd8, 4'd2);
    repeat (5) cyc_drive(1'b1, 8'h3C, 4'd6, 4'd1);
    wait_idle();

    // reset during the 4th bit of an 8-bit transfer
    cyc_drive(1'b1, 8'h96, 4'd8, 4'd1);
    repeat (4) cyc_drive(1'b0, 8'h96, 4'd8, 4'd1);
    @(posedge clk);
    #5;
    reset = 1'b0;
    #1;
    chk("async_reset_gap2", {busy2, bv2, so2, fs2, done2}, 5'b0);
    chk("async_reset_gap0", {busy0, bv0, so0, fs0, done0}, 5'b0);
    q2.delete(); q0.delete();
    nxt2 = 0; nxt0 = 0;
    @(negedge clk);
    @(negedge clk);
    #20;
    reset = 1'b1;
    start = 1'b1; pattern = 8'h0F; patLen = 4'd4; repeatCnt = 4'd1;
    model_edge(cyc + 1, 1'b1, 8'h0F, 4'd4, 4'd1);
    cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);
    wait_idle();

    // repeat count 0 means one pass
    cyc_drive(1'b1, 8'h5A, 4'd5, 4'd0);
    wait_idle();

    // 2-bit pattern twice: contiguous on the GAP=0 instance
    cyc_drive(1'b1, 8'b10, 4'd2, 4'd2);
    wait_idle();

    // start held high: back-to-back transfers as soon as idle
    repeat (40) cyc_drive(1'b1, 8'h05, 4'd3, 4'd1);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc_drive(($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 3)));
    end
    wait_idle();
    repeat (3) cyc_drive(1'b0, 8'h00, 4'd0, 4'd0);

    checks++;
    if (q2.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected q2=%0d q0=%0d", q2.size(), q0.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
